mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Processor memory bus: byte-addressed read strobes and byte-masked writes
// from the initiator, registered read data and status from the target.
interface mem_responder_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rbusy;
    logic        mem_err;

    modport master (
        output mem_addr,
        output mem_rstrb,
        output mem_wdata,
        output mem_wmask,
        input  mem_rdata,
        input  mem_rvalid,
        input  mem_rbusy,
        input  mem_err
    );

    modport slave (
        input  mem_addr,
        input  mem_rstrb,
        input  mem_wdata,
        input  mem_wmask,
        output mem_rdata,
        output mem_rvalid,
        output mem_rbusy,
        output mem_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM target for the processor bus: reads complete after
// LATENCY cycles, writes are single-cycle and byte-masked in any state.
module mem_responder #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 1
) (
    input  logic           CLK,
    input  logic           RESET,
    mem_responder_if.slave bus
);
    localparam int ADDR_BITS = $clog2(WORDS);
    localparam int CNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        RWAIT = 1'b1
    } state_t;

    logic [31:0]          ram [WORDS];

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic                 oor_q, oor_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 err_q, err_d;

    logic [ADDR_BITS-1:0] addr_idx;
    logic                 addr_oor;
    logic                 wr_req;
    logic                 complete;
    logic [ADDR_BITS-1:0] cmp_idx;
    logic                 cmp_oor;
    logic                 unused_addr_lsbs;

    assign addr_idx         = bus.mem_addr[ADDR_BITS+1:2];
    assign addr_oor         = |bus.mem_addr[31:ADDR_BITS+2];
    assign wr_req           = |bus.mem_wmask;
    assign unused_addr_lsbs = ^bus.mem_addr[1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        oor_d    = oor_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        complete = 1'b0;
        cmp_idx  = idx_q;
        cmp_oor  = oor_q;

        case (state_q)
            IDLE: begin
                if (bus.mem_rstrb) begin
                    if (LATENCY == 1) begin
                        // Single-cycle read: completes on the strobe edge itself.
                        complete = 1'b1;
                        cmp_idx  = addr_idx;
                        cmp_oor  = addr_oor;
                    end else begin
                        state_d = RWAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                        idx_d   = addr_idx;
                        oor_d   = addr_oor;
                    end
                end
            end
            RWAIT: begin
                // A strobe here, including on the completion edge, is a protocol error.
                err_d = bus.mem_rstrb;
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The array is sampled before this edge's write lands (read-before-write).
        if (complete) begin
            rvalid_d = 1'b1;
            if (cmp_oor) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                rdata_d = ram[cmp_idx];
            end
        end

        if (wr_req && addr_oor) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            oor_q    <= oor_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_req && !addr_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask[b]) begin
                    ram[addr_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_rdata  = rdata_q;
    assign bus.mem_rvalid = rvalid_q;
    assign bus.mem_rbusy  = (state_q == RWAIT);
    assign bus.mem_err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (LATENCY 1,3,4,5) against an
// edge-timed transaction model of the memory bus.
module tb_mem_responder;
    localparam int NDUT = 4;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    logic CLK;
    logic RESET;

    logic [31:0] s_addr  [NDUT];
    logic        s_rstrb [NDUT];
    logic [31:0] s_wdata [NDUT];
    logic [3:0]  s_wmask [NDUT];
    logic [31:0] o_rdata [NDUT];
    logic        o_rvalid[NDUT];
    logic        o_rbusy [NDUT];
    logic        o_err   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_responder_if bus_i ();
        assign bus_i.mem_addr  = s_addr[g];
        assign bus_i.mem_rstrb = s_rstrb[g];
        assign bus_i.mem_wdata = s_wdata[g];
        assign bus_i.mem_wmask = s_wmask[g];
        assign o_rdata[g]      = bus_i.mem_rdata;
        assign o_rvalid[g]     = bus_i.mem_rvalid;
        assign o_rbusy[g]      = bus_i.mem_rbusy;
        assign o_err[g]        = bus_i.mem_err;

        mem_responder #(.WORDS(256), .LATENCY(lat_of(g))) u_dut (
            .CLK   (CLK),
            .RESET (RESET),
            .bus   (bus_i)
        );
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: reads are transactions with a due edge number.
    logic [31:0] m_arr  [NDUT][256];
    bit          m_pend [NDUT];
    int unsigned m_due  [NDUT];
    logic [7:0]  m_idx  [NDUT];
    bit          m_oor  [NDUT];
    logic [31:0] e_rdata[NDUT];
    bit          e_rvalid[NDUT];
    bit          e_rbusy[NDUT];
    bit          e_err  [NDUT];
    int unsigned cyc;

    int n_vec;
    int n_bad;

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_pend[d]   = 1'b0;
            e_rdata[d]  = 32'h0;
            e_rvalid[d] = 1'b0;
            e_rbusy[d]  = 1'b0;
            e_err[d]    = 1'b0;
        end
    endtask

    task automatic model_edge(input int d);
        bit         busy_here;
        bit         hit;
        bit         oor;
        bit         coor;
        logic [7:0] widx;
        logic [7:0] cidx;
        busy_here   = m_pend[d];
        oor         = (s_addr[d][31:10] != 0);
        widx        = s_addr[d][9:2];
        hit         = 1'b0;
        coor        = 1'b0;
        cidx        = 8'h0;
        e_rvalid[d] = 1'b0;
        e_err[d]    = 1'b0;
        if (m_pend[d] && cyc == m_due[d]) begin
            hit       = 1'b1;
            cidx      = m_idx[d];
            coor      = m_oor[d];
            m_pend[d] = 1'b0;
        end
        if (s_rstrb[d]) begin
            if (busy_here) begin
                e_err[d] = 1'b1;
            end else if (lat_of(d) == 1) begin
                hit  = 1'b1;
                cidx = widx;
                coor = oor;
            end else begin
                m_pend[d] = 1'b1;
                m_due[d]  = cyc + lat_of(d) - 1;
                m_idx[d]  = widx;
                m_oor[d]  = oor;
            end
        end
        if (hit) begin
            e_rvalid[d] = 1'b1;
            if (coor) begin
                e_rdata[d] = 32'h0;
                e_err[d]   = 1'b1;
            end else begin
                e_rdata[d] = m_arr[d][cidx];
            end
        end
        if (s_wmask[d] != 4'h0) begin
            if (oor) e_err[d] = 1'b1;
            else begin
                for (int b = 0; b < 4; b++)
                    if (s_wmask[d][b]) m_arr[d][widx][8*b +: 8] = s_wdata[d][8*b +: 8];
            end
        end
        e_rbusy[d] = m_pend[d];
    endtask

    task automatic idle_all();
        for (int d = 0; d < NDUT; d++) begin
            s_addr[d]  = 32'h0;
            s_rstrb[d] = 1'b0;
            s_wdata[d] = 32'h0;
            s_wmask[d] = 4'h0;
        end
    endtask

    // One rising edge: model predicts, DUTs clock, stimulus returns to idle.
    task automatic step();
        cyc++;
        for (int d = 0; d < NDUT; d++) model_edge(d);
        @(negedge CLK);
        idle_all();
    endtask

    task automatic preload();
        for (int w = 0; w < 16; w++) begin
            for (int d = 0; d < NDUT; d++) begin
                s_addr[d]  = 32'(w) << 2;
                s_wdata[d] = $urandom;
                s_wmask[d] = 4'hF;
            end
            step();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle_all();
        repeat (2) @(negedge CLK);
        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if (o_rdata[d] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, o_rdata[d]); end
            n_vec++;
            if (o_rvalid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid dut%0d: got %b want 0", d, o_rvalid[d]); end
            n_vec++;
            if (o_rbusy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_rbusy dut%0d: got %b want 0", d, o_rbusy[d]); end
            n_vec++;
            if (o_err[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err dut%0d: got %b want 0", d, o_err[d]); end
        end
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
    endtask

    task automatic test_latency1();
        s_addr[0] = 32'h14; s_wdata[0] = 32'hDEADBEEF; s_wmask[0] = 4'hF;
        step();
        s_addr[0] = 32'h14; s_rstrb[0] = 1'b1;
        step();
        n_vec++;
        if (o_rdata[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lat1_rdata: got %h want deadbeef", o_rdata[0]); end
        n_vec++;
        if (o_rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL lat1_rvalid: got %b want 1", o_rvalid[0]); end
        n_vec++;
        if (o_rbusy[0] !== 1'b0) begin n_bad++; $display("FAIL lat1_rbusy: got %b want 0", o_rbusy[0]); end
        step();
        n_vec++;
        if (o_rvalid[0] !== 1'b0) begin n_bad++; $display("FAIL lat1_rvalid_drop: got %b want 0", o_rvalid[0]); end
        n_vec++;
        if (o_rdata[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lat1_rdata_hold: got %h want deadbeef", o_rdata[0]); end
    endtask

    task automatic test_latency3();
        s_addr[1] = 32'h08; s_wdata[1] = 32'h12345678; s_wmask[1] = 4'hF;
        step();
        s_addr[1] = 32'h08; s_rstrb[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_vec++;
            if (o_rbusy[1] !== (k < 3)) begin n_bad++; $display("FAIL lat3_rbusy k=%0d: got %b want %b", k, o_rbusy[1], (k < 3)); end
            n_vec++;
            if (o_rvalid[1] !== (k == 3)) begin n_bad++; $display("FAIL lat3_rvalid k=%0d: got %b want %b", k, o_rvalid[1], (k == 3)); end
        end
        n_vec++;
        if (o_rdata[1] !== 32'h12345678) begin n_bad++; $display("FAIL lat3_rdata: got %h want 12345678", o_rdata[1]); end
    endtask

    task automatic test_byte_mask();
        s_addr[0] = 32'h0; s_wdata[0] = 32'hAABBCCDD; s_wmask[0] = 4'hF;
        step();
        s_addr[0] = 32'h0; s_wdata[0] = 32'h11223344; s_wmask[0] = 4'b0101;
        step();
        s_addr[0] = 32'h0; s_rstrb[0] = 1'b1;
        step();
        n_vec++;
        if (o_rdata[0] !== 32'hAA22CC44) begin n_bad++; $display("FAIL byte_mask_rdata: got %h want aa22cc44", o_rdata[0]); end
        n_vec++;
        if (o_rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL byte_mask_rvalid: got %b want 1", o_rvalid[0]); end
    endtask

    task automatic test_out_of_range();
        s_addr[2] = 32'h0; s_wdata[2] = 32'h55AA55AA; s_wmask[2] = 4'hF;
        step();
        s_addr[2] = 32'h0; s_rstrb[2] = 1'b1;
        repeat (4) step();
        s_addr[2] = 32'h400; s_rstrb[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_vec++;
            if (o_err[2] !== (k == 4)) begin n_bad++; $display("FAIL oor_read_err k=%0d: got %b want %b", k, o_err[2], (k == 4)); end
        end
        n_vec++;
        if (o_rdata[2] !== 32'h0) begin n_bad++; $display("FAIL oor_read_rdata: got %h want 0", o_rdata[2]); end
        n_vec++;
        if (o_rvalid[2] !== 1'b1) begin n_bad++; $display("FAIL oor_read_rvalid: got %b want 1", o_rvalid[2]); end
        s_addr[2] = 32'h400; s_wdata[2] = 32'hFFFFFFFF; s_wmask[2] = 4'hF;
        step();
        n_vec++;
        if (o_err[2] !== 1'b1) begin n_bad++; $display("FAIL oor_write_err: got %b want 1", o_err[2]); end
        step();
        n_vec++;
        if (o_err[2] !== 1'b0) begin n_bad++; $display("FAIL oor_write_err_drop: got %b want 0", o_err[2]); end
        s_addr[2] = 32'h0; s_rstrb[2] = 1'b1;
        repeat (4) step();
        n_vec++;
        if (o_rdata[2] !== 32'h55AA55AA) begin n_bad++; $display("FAIL oor_word0_kept: got %h want 55aa55aa", o_rdata[2]); end
    endtask

    task automatic test_busy_strobe();
        int nvalid;
        s_addr[1] = 32'h1C; s_wdata[1] = 32'h0; s_wmask[1] = 4'hF;
        step();
        s_addr[1] = 32'h1C; s_rstrb[1] = 1'b1;
        step();
        n_vec++;
        if (o_err[1] !== 1'b0) begin n_bad++; $display("FAIL busy_first_err: got %b want 0", o_err[1]); end
        s_addr[1] = 32'h1C; s_rstrb[1] = 1'b1; s_wdata[1] = 32'hCAFEF00D; s_wmask[1] = 4'hF;
        step();
        n_vec++;
        if (o_err[1] !== 1'b1) begin n_bad++; $display("FAIL busy_second_err: got %b want 1", o_err[1]); end
        n_vec++;
        if (o_rbusy[1] !== 1'b1) begin n_bad++; $display("FAIL busy_still_busy: got %b want 1", o_rbusy[1]); end
        step();
        n_vec++;
        if (o_rdata[1] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL busy_late_write_data: got %h want cafef00d", o_rdata[1]); end
        nvalid = int'(o_rvalid[1]);
        repeat (4) begin
            step();
            nvalid += int'(o_rvalid[1]);
        end
        n_vec++;
        if (nvalid != 1) begin n_bad++; $display("FAIL busy_single_rvalid: got %0d pulses want 1", nvalid); end
    endtask

    task automatic test_reset_mid_read();
        s_addr[3] = 32'h0C; s_wdata[3] = 32'h0BADF00D; s_wmask[3] = 4'hF;
        step();
        s_addr[3] = 32'h0C; s_rstrb[3] = 1'b1;
        repeat (5) step();
        n_vec++;
        if (o_rdata[3] !== 32'h0BADF00D) begin n_bad++; $display("FAIL rst_pre_rdata: got %h want 0badf00d", o_rdata[3]); end
        s_addr[3] = 32'h0C; s_rstrb[3] = 1'b1;
        repeat (2) step();
        RESET = 1'b1;
        #1;
        n_vec++;
        if (o_rbusy[3] !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rbusy: got %b want 0", o_rbusy[3]); end
        n_vec++;
        if (o_rdata[3] !== 32'h0) begin n_bad++; $display("FAIL rst_mid_rdata: got %h want 0", o_rdata[3]); end
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_vec++;
            if (o_rvalid[3] !== 1'b0) begin n_bad++; $display("FAIL rst_no_rvalid k=%0d: got %b want 0", k, o_rvalid[3]); end
        end
        s_addr[3] = 32'h0C; s_rstrb[3] = 1'b1;
        repeat (5) step();
        n_vec++;
        if (o_rdata[3] !== 32'h0BADF00D || o_rvalid[3] !== 1'b1) begin
            n_bad++; $display("FAIL rst_array_kept: got %h/%b want 0badf00d/1", o_rdata[3], o_rvalid[3]);
        end
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 8; w++) begin
            s_addr[0] = 32'(w) << 2; s_rstrb[0] = 1'b1;
            step();
            n_vec++;
            if (o_rdata[0] !== e_rdata[0] || o_rvalid[0] !== 1'b1) begin
                n_bad++; $display("FAIL b2b w=%0d: got %h/%b want %h/1", w, o_rdata[0], o_rvalid[0], e_rdata[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < NDUT; d++) begin
                s_addr[d]  = {22'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
                if ($urandom_range(0, 15) == 0) s_addr[d] = s_addr[d] | (32'h400 << $urandom_range(0, 21));
                s_rstrb[d] = ($urandom_range(0, 2) == 0);
                s_wdata[d] = $urandom;
                s_wmask[d] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            step();
            for (int d = 0; d < NDUT; d++) begin
                n_vec++;
                if (o_rdata[d] !== e_rdata[d] || o_rvalid[d] !== e_rvalid[d] ||
                    o_rbusy[d] !== e_rbusy[d] || o_err[d] !== e_err[d]) begin
                    n_bad++;
                    $display("FAIL random n=%0d dut%0d: got %h/%b/%b/%b want %h/%b/%b/%b", n, d,
                             o_rdata[d], o_rvalid[d], o_rbusy[d], o_err[d],
                             e_rdata[d], e_rvalid[d], e_rbusy[d], e_err[d]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        RESET = 1'b1;
        idle_all();
        model_reset();
        test_reset();
        preload();
        test_latency1();
        test_latency3();
        test_byte_mask();
        test_out_of_range();
        test_busy_strobe();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
